// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - shared constants for the SQED instruction duplicator
// Contents: RV32 opcode constants, the NOP word, register field positions,
// the default duplicate register offset and the queued entry layout.
package qed_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int FIELD_W = 5;

  localparam int DUP_OFFSET_DEF = 16;

  // Queue entry: the raw original plus its "counts toward QED" flag.
  typedef struct packed {
    logic [31:0] inst;
    logic        qed;
  } fifo_entry_t;

endpackage

// File: rtl/qed_inst_fifo.sv
// rtl/qed_inst_fifo.sv - synchronous FIFO of queued originals (instruction + qed flag)
// Ports:
//   clk, rst        clock, synchronous active-low reset (clears pointers/count)
//   push, push_data write one entry (ignored when full)
//   pop, pop_data   pop_data is the current head; pop advances it (ignored when empty)
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
module qed_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/qed_dup_gen.sv
// rtl/qed_dup_gen.sv - SQED instruction duplicator between fetch and IF/ID
// Optional feature macro: QED_FILTER_EN (control-flow/system/fence originals become NOP, not counted).
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   inst_i, inst_vld_i       fetched instruction and its valid
//   inst_rdy_o               fetch accepted when inst_vld_i && inst_rdy_o
//   exec_dup_i               free select: request a duplicate issue
//   inst_o, inst_vld_o       registered instruction to IF/ID and its valid
//   out_rdy_i                pipeline can take inst_o
//   is_dup_o                 inst_o is a duplicate
//   qed_vld_o                inst_o counts toward the QED commit counters
//   orig_cnt_o, dup_cnt_o    originals / duplicates issued (wrapping)
//   fifo_cnt_o               queued originals awaiting duplication
module qed_dup_gen
  import qed_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DUP_OFFSET = DUP_OFFSET_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   inst_i,
  input  logic                          inst_vld_i,
  output logic                          inst_rdy_o,
  input  logic                          exec_dup_i,
  output logic [31:0]                   inst_o,
  output logic                          inst_vld_o,
  input  logic                          out_rdy_i,
  output logic                          is_dup_o,
  output logic                          qed_vld_o,
  output logic [CNT_W-1:0]              orig_cnt_o,
  output logic [CNT_W-1:0]              dup_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam logic [FIELD_W-1:0] OFF = FIELD_W'(DUP_OFFSET);

  // Which register fields an opcode actually uses: {rd, rs1, rs2}.
  function automatic logic [2:0] used_fields(input logic [6:0] opc);
    case (opc)
      OPC_OP:              used_fields = 3'b111;
      OPC_OP_IMM,
      OPC_LOAD:            used_fields = 3'b110;
      OPC_STORE:           used_fields = 3'b011;
      OPC_LUI, OPC_AUIPC:  used_fields = 3'b100;
      default:             used_fields = 3'b000;
    endcase
  endfunction

  function automatic logic [FIELD_W-1:0] shift_reg(input logic [FIELD_W-1:0] f);
    shift_reg = (f == '0) ? f : f + OFF;
  endfunction

  function automatic logic [31:0] remap(input logic [31:0] inst);
    logic [2:0] use_f;
    remap = inst;
    use_f = used_fields(inst[6:0]);
    if (use_f[2]) remap[RD_LSB  +: FIELD_W] = shift_reg(inst[RD_LSB  +: FIELD_W]);
    if (use_f[1]) remap[RS1_LSB +: FIELD_W] = shift_reg(inst[RS1_LSB +: FIELD_W]);
    if (use_f[0]) remap[RS2_LSB +: FIELD_W] = shift_reg(inst[RS2_LSB +: FIELD_W]);
  endfunction

  // An original touching x16..x31 in a used field would alias the duplicate
  // register half, so it is issued but kept out of the commit counters.
  function automatic logic fields_legal(input logic [31:0] inst);
    logic [2:0] use_f;
    use_f = used_fields(inst[6:0]);
    fields_legal = !(use_f[2] && inst[RD_LSB  + FIELD_W - 1]) &&
                   !(use_f[1] && inst[RS1_LSB + FIELD_W - 1]) &&
                   !(use_f[0] && inst[RS2_LSB + FIELD_W - 1]);
  endfunction

  logic        load;
  logic        issue_dup;
  logic        issue_orig;
  logic        fifo_full;
  logic        fifo_empty;
  fifo_entry_t head;
  fifo_entry_t orig_entry;

`ifdef QED_FILTER_EN
  logic is_filtered;
  always_comb begin
    case (inst_i[6:0])
      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_FENCE: is_filtered = 1'b1;
      default:                                              is_filtered = 1'b0;
    endcase
  end
  assign orig_entry.inst = is_filtered ? NOP_INST : inst_i;
  assign orig_entry.qed  = !is_filtered && fields_legal(inst_i);
`else
  assign orig_entry.inst = inst_i;
  assign orig_entry.qed  = fields_legal(inst_i);
`endif

  // A duplicate always wins; a full queue forces one so the queue drains.
  assign load       = !inst_vld_o || out_rdy_i;
  assign issue_dup  = load && !fifo_empty && (exec_dup_i || fifo_full);
  assign issue_orig = load && !issue_dup && inst_vld_i && !fifo_full;
  assign inst_rdy_o = load && !issue_dup && !fifo_full;

  qed_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_orig),
    .push_data (orig_entry),
    .pop       (issue_dup),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt_o)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_o     <= NOP_INST;
      inst_vld_o <= 1'b0;
      is_dup_o   <= 1'b0;
      qed_vld_o  <= 1'b0;
      orig_cnt_o <= '0;
      dup_cnt_o  <= '0;
    end else if (load) begin
      if (issue_dup) begin
        inst_o     <= remap(head.inst);
        inst_vld_o <= 1'b1;
        is_dup_o   <= 1'b1;
        qed_vld_o  <= head.qed;
        dup_cnt_o  <= dup_cnt_o + 1'b1;
      end else if (issue_orig) begin
        inst_o     <= orig_entry.inst;
        inst_vld_o <= 1'b1;
        is_dup_o   <= 1'b0;
        qed_vld_o  <= orig_entry.qed;
        orig_cnt_o <= orig_cnt_o + 1'b1;
      end else begin
        inst_o     <= NOP_INST;
        inst_vld_o <= 1'b0;
        is_dup_o   <= 1'b0;
        qed_vld_o  <= 1'b0;
      end
    end
  end

endmodule
